// File: rtl/mips_pkg.sv
// Shared constants and the address-region type for the MIPS memory/IO responder.
package mips_pkg;

  localparam logic [31:0] INPORT0_ADDR         = 32'h0000_FFF8;
  localparam logic [31:0] INPORT1_OUTPORT_ADDR = 32'h0000_FFFC;

  typedef enum logic [1:0] {
    RGN_RAM,
    RGN_IN0,
    RGN_IN1,
    RGN_NONE
  } mem_region_t;

endpackage

// File: rtl/ram_sync_1p.sv
// Single-port synchronous RAM with registered read-first output; contents are never reset.
module ram_sync_1p #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mips_mem_io.sv
// Memory and memory-mapped I/O responder for the multi-cycle MIPS datapath.
// Optional build macro MIPS_MEM_INPORT_SYNC_EN: synchronize and edge-detect the input-port enables.
module mips_mem_io
  import mips_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int RAM_WORDS = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             mem_write,
  input  logic [WIDTH-1:0] sw_data,
  input  logic             inport0_en,
  input  logic             inport1_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] outport
);

  localparam int               AW        = $clog2(RAM_WORDS);
  localparam logic [WIDTH-1:0] RAM_BYTES = WIDTH'(RAM_WORDS * 4);
  localparam logic [WIDTH-1:0] IN0_A     = WIDTH'(INPORT0_ADDR);
  localparam logic [WIDTH-1:0] IN1_A     = WIDTH'(INPORT1_OUTPORT_ADDR);

  mem_region_t      rgn;
  mem_region_t      rd_sel_q;
  logic [WIDTH-1:0] port_rd_q;
  logic [WIDTH-1:0] ram_rdata;
  logic [WIDTH-1:0] in0_q;
  logic [WIDTH-1:0] in1_q;
  logic             ram_we;
  logic             out_we;
  logic             ld0;
  logic             ld1;

  always_comb begin
    rgn = RGN_NONE;
    if (addr < RAM_BYTES)                    rgn = RGN_RAM;
    else if (addr[WIDTH-1:2] == IN0_A[WIDTH-1:2]) rgn = RGN_IN0;
    else if (addr[WIDTH-1:2] == IN1_A[WIDTH-1:2]) rgn = RGN_IN1;
  end

  // RAM writes are held off while reset is asserted so a held reset cannot corrupt contents.
  assign ram_we = mem_write && (rgn == RGN_RAM) && rst;
  assign out_we = mem_write && (rgn == RGN_IN1);

  ram_sync_1p #(
    .WIDTH (WIDTH),
    .DEPTH (RAM_WORDS)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (addr[AW+1:2]),
    .wdata (wr_data),
    .rdata (ram_rdata)
  );

`ifdef MIPS_MEM_INPORT_SYNC_EN
  logic [2:0] en0_sh;
  logic [2:0] en1_sh;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en0_sh <= '0;
      en1_sh <= '0;
    end else begin
      en0_sh <= {en0_sh[1:0], inport0_en};
      en1_sh <= {en1_sh[1:0], inport1_en};
    end
  end

  // Two sync stages, third stage only for rise detection.
  assign ld0 = en0_sh[1] && !en0_sh[2];
  assign ld1 = en1_sh[1] && !en1_sh[2];
`else
  assign ld0 = inport0_en;
  assign ld1 = inport1_en;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in0_q   <= '0;
      in1_q   <= '0;
      outport <= '0;
    end else begin
      if (ld0)    in0_q   <= sw_data;
      if (ld1)    in1_q   <= sw_data;
      if (out_we) outport <= wr_data;
    end
  end

  // Port reads are captured at the address edge so the value holds even if the port reloads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_sel_q  <= RGN_NONE;
      port_rd_q <= '0;
    end else begin
      rd_sel_q <= rgn;
      case (rgn)
        RGN_IN0: port_rd_q <= in0_q;
        RGN_IN1: port_rd_q <= in1_q;
        default: port_rd_q <= '0;
      endcase
    end
  end

  assign rd_data = (rd_sel_q == RGN_RAM) ? ram_rdata : port_rd_q;

endmodule

// File: doc/mips_mem_io.md
# mips_mem_io

Memory-and-I/O responder for the multi-cycle MIPS datapath: services every instruction fetch and data load/store issued under controller `i_or_d`/`mem_write` control. It contains word-addressed synchronous RAM plus memory-mapped input and output ports. Read data is registered, so it is valid one cycle after the address, which lines up with the controller's IR/MDR load states. Sits between the datapath address/write-data bus and board-level switches and LEDs.

## Interface
- `WIDTH`, 32: data and address width.
- `RAM_WORDS`, 256: RAM depth in words; power of two, at most 1024.
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `addr`  in  WIDTH  byte address from the datapath address mux.
- `wr_data`  in  WIDTH  store data (register-file B output).
- `mem_write`  in  1  store strobe from the controller.
- `sw_data`  in  WIDTH  switch value shared by both input ports.
- `inport0_en`  in  1  load `sw_data` into input port 0.
- `inport1_en`  in  1  load `sw_data` into input port 1.
- `rd_data`  out  WIDTH  registered read data to IR/MDR.
- `outport`  out  WIDTH  output port register to LEDs/display.

## Operation
- Address map (byte addresses; `addr[1:0]` ignored):
  - RAM: `addr < RAM_WORDS*4`, word index `addr[$clog2(RAM_WORDS)+1:2]`.
  - INPORT0: 0x0000FFF8, read-only.
  - INPORT1 / OUTPORT: 0x0000FFFC. Reads return INPORT1. Writes go to OUTPORT.
  - Other addresses: writes ignored, reads return 0.
- Writes: when `mem_write`=1 and the address decodes to RAM, the RAM word is written at the clock edge. When `mem_write`=1 and the address is 0xFFFC, `outport` takes `wr_data`. A write has no other side effects.
- Reads happen every cycle, regardless of `mem_write`. A read-select register captures the region decode (RAM/IN0/IN1/NONE) at the same edge as the RAM read, and the output mux uses it. `rd_data` is registered.
- Read-during-write to the same RAM word: `rd_data` returns the old contents (read-first).
- Input ports: `inport0_en` and `inport1_en` each load `sw_data` into their own register. If both are high in one cycle, both ports load.
- Input ports are never written by `mem_write`.

## Timing
- Read latency is 1 cycle. An address presented before edge N gives data on `rd_data` after edge N, stable through edge N+1.
- A store is visible to a read issued on the next cycle.
- An outport write is visible on `outport` immediately after the write edge.
- Reset values:
  - `rd_data`=0, `outport`=0, INPORT0=0, INPORT1=0, read-select=NONE.
  - RAM contents are not reset; they are preserved across reset.
- Reset mid-access: the pending read is discarded and `rd_data` forces 0 asynchronously. A write coincident with reset assertion has an undefined effect on RAM only.

## Configuration
- `MIPS_MEM_INPORT_SYNC_EN` defined:
  - `inport0_en` and `inport1_en` each pass through a 2-flop synchronizer and a rising-edge detector.
  - A port loads once per enable assertion, 3 cycles after the enable rises.
  - `sw_data` is sampled at that load cycle.
- Not defined: the enables are used as level loads, directly in the cycle they are high.

## Structure
- Package `mips_pkg` holds:
  - `INPORT0_ADDR` and `INPORT1_OUTPORT_ADDR` constants.
  - the `mem_region_t` enum {RGN_RAM, RGN_IN0, RGN_IN1, RGN_NONE}.
- One sub-module, `ram_sync_1p`:
  - single-port synchronous RAM, read-first;
  - parameters WIDTH and DEPTH; ports clk, we, addr, wdata, rdata;
  - not reset.
- Decode, port registers and the output mux live in the top module.

## Test plan
- Reset release, then read 0xFFF8 and 0xFFFC → `rd_data`=0 one cycle later; `outport`=0.
- Write 0xDEADBEEF to 0x00000010, then read 0x10 on the next cycle → `rd_data`=0xDEADBEEF. Read 0x13 → same word.
- Write 0x1234 and read 0x20 in the same cycle (old value 0xAAAA) → `rd_data`=0xAAAA; the following read returns 0x1234.
- `sw_data`=0x1FF with `inport1_en` pulsed, then read 0xFFFC → 0x1FF. Write 0x55 to 0xFFFC → `outport`=0x55; INPORT1 still reads 0x1FF.
- Write to 0x8000 (unmapped), then read 0x8000 → 0; RAM and `outport` unchanged.
- With `MIPS_MEM_INPORT_SYNC_EN` defined, hold `inport0_en` high for 10 cycles → INPORT0 loads exactly once, 3 cycles after the rise. Then assert `rst` mid-read → `rd_data`=0 immediately and RAM contents are retained.
